// File: rtl/video_wr_arbiter.sv
// Four-port round-robin arbiter sharing one AXI write channel between frame writers.
// Define ARB_CH0_PRIORITY_EN to give channel 0 (HDMI input) absolute priority over channels 1-3.
module video_wr_arbiter #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int M_AXI_BRUST_LEN = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          ddr_init_done,
    input  logic [3:0]                    wr_req,
    input  logic [4*CTRL_ADDR_WIDTH-1:0]  wr_addr,
    input  logic [4*AXI_DATA_WIDTH-1:0]   wr_data,
    output logic [3:0]                    wr_grant,
    output logic [3:0]                    wr_data_req,
    output logic [3:0]                    wr_done,
    output logic [CTRL_ADDR_WIDTH-1:0]    axi_awaddr,
    output logic [3:0]                    axi_awlen,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                          axi_wlast,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic                          axi_bvalid,
    output logic                          axi_bready,
    output logic                          busy,
    output logic [1:0]                    dbg_state
);

    // Every AXI channel transfers exactly in the cycle where its valid and ready are
    // both high; valid never depends on ready, and payload is held until that cycle.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(M_AXI_BRUST_LEN - 1);

    state_t                      state;
    state_t                      state_nxt;
    logic [1:0]                  sel;
    logic [1:0]                  rr_last;
    logic [1:0]                  pick;
    logic                        pick_valid;
    logic [3:0]                  beat_cnt;
    logic                        grant_pend;
    logic                        start;
    logic                        aw_hs;
    logic                        w_hs;
    logic                        b_hs;
    logic [3:0]                  sel_oh;
    logic [AXI_DATA_WIDTH-1:0]   ch_data [4];
    logic [CTRL_ADDR_WIDTH-1:0]  ch_addr [4];

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign ch_data[g] = wr_data[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        assign ch_addr[g] = wr_addr[g*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
    end

    // Scan offsets 4 down to 1 so the nearest requester after rr_last is written last.
    always_comb begin
        logic [1:0] cand;
        cand       = 2'd0;
        pick       = 2'd0;
        pick_valid = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            cand = rr_last + 2'(k);
`ifdef ARB_CH0_PRIORITY_EN
            if (wr_req[cand] && (cand != 2'd0)) begin
`else
            if (wr_req[cand]) begin
`endif
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
`ifdef ARB_CH0_PRIORITY_EN
        if (wr_req[0]) begin
            pick       = 2'd0;
            pick_valid = 1'b1;
        end
`endif
    end

    assign start = (state == ST_IDLE) && ddr_init_done && pick_valid;
    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid & axi_wready;
    assign b_hs  = axi_bready & axi_bvalid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)              state_nxt = ST_AW;
            ST_AW:   if (aw_hs)              state_nxt = ST_W;
            ST_W:    if (w_hs && axi_wlast)  state_nxt = ST_B;
            ST_B:    if (b_hs)               state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_oh      = 4'b0001 << sel;
        axi_awvalid = (state == ST_AW);
        axi_wvalid  = (state == ST_W);
        axi_bready  = (state == ST_B);
        busy        = (state != ST_IDLE);
        axi_wlast   = (state == ST_W) && (beat_cnt == LAST_BEAT);
        axi_wdata   = (state == ST_W) ? ch_data[sel] : '0;
        wr_grant    = grant_pend ? sel_oh : 4'b0000;
        wr_data_req = w_hs ? sel_oh : 4'b0000;
        wr_done     = b_hs ? sel_oh : 4'b0000;
        dbg_state   = state;
    end

    assign axi_awlen = LAST_BEAT;
    assign axi_wstrb = '1;

    // Burst bookkeeping: winner, its address, beat count and the round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel        <= 2'd0;
            rr_last    <= 2'd3;
            axi_awaddr <= '0;
            beat_cnt   <= 4'd0;
            grant_pend <= 1'b0;
        end else begin
            grant_pend <= start;
            if (start) begin
                sel        <= pick;
                axi_awaddr <= ch_addr[pick];
            end
            if (aw_hs) begin
                beat_cnt <= 4'd0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
            if (b_hs) begin
`ifdef ARB_CH0_PRIORITY_EN
                if (sel != 2'd0) begin
                    rr_last <= sel;
                end
`else
                rr_last <= sel;
`endif
            end
        end
    end

endmodule

// File: tb/tb_video_wr_arbiter.sv
// Randomized bench for video_wr_arbiter against a burst-level reference model.
module tb_video_wr_arbiter;
  localparam int AW  = 28;
  localparam int DW  = 256;
  localparam int LEN = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              ddr_init_done;
  logic [3:0]        wr_req;
  logic [4*AW-1:0]   wr_addr;
  logic [4*DW-1:0]   wr_data;
  logic [3:0]        wr_grant;
  logic [3:0]        wr_data_req;
  logic [3:0]        wr_done;
  logic [AW-1:0]     axi_awaddr;
  logic [3:0]        axi_awlen;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [DW-1:0]     axi_wdata;
  logic [DW/8-1:0]   axi_wstrb;
  logic              axi_wlast;
  logic              axi_wvalid;
  logic              axi_wready;
  logic              axi_bvalid;
  logic              axi_bready;
  logic              busy;
  logic [1:0]        dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  video_wr_arbiter #(
    .CTRL_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .M_AXI_BRUST_LEN(LEN)
  ) dut (
    .clk(clk), .rstn(rstn), .ddr_init_done(ddr_init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_grant(wr_grant), .wr_data_req(wr_data_req), .wr_done(wr_done),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .busy(busy),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // writer FIFOs: the head word of channel n is a function of how many words it has given up
  int word_cnt [4] = '{0, 0, 0, 0};

  function automatic logic [DW-1:0] beat_word(input int ch, input int cnt);
    logic [7:0]  c;
    logic [23:0] n;
    c = 8'(ch + 8'hc0);
    n = 24'(cnt);
    return {8{c, n}};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_writer
    assign wr_data[g*DW +: DW] = beat_word(g, word_cnt[g]);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one burst at a time, winner chosen by scanning channels after the last one served
  int            m_phase;     // 0 waiting, 1 address, 2 data, 3 response
  int            m_ch;
  int            m_beats;
  int            m_rr_last;
  int            m_done_cnt = 0;
  bit            m_grant;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] exp_q[$];
  int            adv_ch;
  int            gnt_ch;

  // stimulus knobs (percent probabilities)
  int p_aw, p_w, p_b, p_init, p_req;
  bit hold_all;

  function automatic int pick(input logic [3:0] req, input int last);
    int order[$];
`ifdef ARB_CH0_PRIORITY_EN
    if (req[0]) return 0;
`endif
    for (int k = 1; k <= 4; k++) order.push_back((last + k) % 4);
    foreach (order[i]) begin
`ifdef ARB_CH0_PRIORITY_EN
      if (order[i] == 0) continue;
`endif
      if (req[order[i]]) return order[i];
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_ch      = 0;
    m_beats   = 0;
    m_rr_last = 3;
    m_grant   = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic [3:0] oh;
    oh = 4'b0001 << m_ch;
    check("awvalid", axi_awvalid, m_phase == 1);
    check("grant", wr_grant, m_grant ? oh : 4'b0000);
    if (m_phase == 1) check("awaddr", axi_awaddr, m_addr);
    check("awlen", axi_awlen, 4'(LEN - 1));
    check("wvalid", axi_wvalid, m_phase == 2);
    check("wlast", axi_wlast, (m_phase == 2) && (m_beats == LEN - 1));
    check("data_req", wr_data_req, (m_phase == 2 && axi_wready) ? oh : 4'b0000);
    if (m_phase == 2 && axi_wready) begin
      if (exp_q.size() == 0) check("wdata_extra_beat", 1'b1, 1'b0);
      else check("wdata", axi_wdata, exp_q.pop_front());
    end
    check("bready", axi_bready, m_phase == 3);
    check("done", wr_done, (m_phase == 3 && axi_bvalid) ? oh : 4'b0000);
    check("busy", busy, m_phase != 0);
  endtask

  task automatic model_advance();
    adv_ch = -1;
    gnt_ch = -1;
    case (m_phase)
      0: begin
        int c;
        c = pick(wr_req, m_rr_last);
        if (ddr_init_done && c >= 0) begin
          m_ch    = c;
          m_addr  = wr_addr[c*AW +: AW];
          m_phase = 1;
          m_grant = 1'b1;
          gnt_ch  = c;
          for (int i = 0; i < LEN; i++) exp_q.push_back(beat_word(c, word_cnt[c] + i));
        end
      end
      1: begin
        m_grant = 1'b0;
        if (axi_awready) begin
          m_phase = 2;
          m_beats = 0;
        end
      end
      2: if (axi_wready) begin
        adv_ch = m_ch;
        m_beats++;
        if (m_beats == LEN) m_phase = 3;
      end
      default: if (axi_bvalid) begin
        m_phase = 0;
        m_done_cnt++;
`ifdef ARB_CH0_PRIORITY_EN
        if (m_ch != 0) m_rr_last = m_ch;
`else
        m_rr_last = m_ch;
`endif
      end
    endcase
  endtask

  // driver tasks
  task automatic new_request(input int n);
    wr_req[n] = 1'b1;
    wr_addr[n*AW +: AW] = AW'($urandom);
  endtask

  task automatic drive_random();
    axi_awready   = $urandom_range(99, 0) < p_aw;
    axi_wready    = $urandom_range(99, 0) < p_w;
    axi_bvalid    = $urandom_range(99, 0) < p_b;
    ddr_init_done = $urandom_range(99, 0) < p_init;
    for (int n = 0; n < 4; n++)
      if (!wr_req[n] && $urandom_range(99, 0) < p_req) new_request(n);
  endtask

  task automatic apply_effects();
    if (adv_ch >= 0) word_cnt[adv_ch]++;
    if (gnt_ch >= 0) begin
      if (hold_all || $urandom_range(1, 0) == 1) new_request(gnt_ch);
      else wr_req[gnt_ch] = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
    apply_effects();
    drive_random();
  endtask

  task automatic run_until_done(input int target, input int budget);
    while (m_done_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    if (m_done_cnt < target) check("burst_budget", 32'(m_done_cnt), 32'(target));
  endtask

  task automatic set_knobs(input int aw, input int w, input int b, input int init, input int req, input bit hold);
    p_aw = aw; p_w = w; p_b = b; p_init = init; p_req = req; hold_all = hold;
  endtask

  initial begin
    int budget;
    rstn = 1'b0;
    ddr_init_done = 1'b0;
    wr_req = 4'b0000;
    wr_addr = '0;
    axi_awready = 1'b0;
    axi_wready = 1'b0;
    axi_bvalid = 1'b0;
    model_reset();
    #3;
    check("rst_awvalid", axi_awvalid, 1'b0);
    check("rst_wvalid", axi_wvalid, 1'b0);
    check("rst_wlast", axi_wlast, 1'b0);
    check("rst_bready", axi_bready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", wr_grant, 4'b0000);
    check("rst_awaddr", axi_awaddr, '0);
    check("rst_wdata", axi_wdata, '0);
    check("rst_awlen", axi_awlen, 4'(LEN - 1));
    check("rst_wstrb", axi_wstrb, {(DW/8){1'b1}});
    @(posedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b1;

    // calibration not done: channel 2 waits, then starts once init rises
    set_knobs(100, 100, 100, 0, 0, 1'b0);
    new_request(2);
    for (int i = 0; i < 10; i++) step();
    p_init = 100;
    run_until_done(m_done_cnt + 1, 40);

    // all four held, slave always ready
    set_knobs(100, 100, 100, 100, 100, 1'b1);
    run_until_done(m_done_cnt + 5, 200);

    // random stalls on every channel
    set_knobs(40, 50, 30, 90, 30, 1'b0);
    for (int i = 0; i < 1500; i++) step();

    // slow write response
    set_knobs(70, 70, 5, 100, 40, 1'b0);
    for (int i = 0; i < 600; i++) step();

    // async reset in the middle of a burst
    set_knobs(100, 60, 100, 100, 100, 1'b1);
    budget = 300;
    while (!(m_phase == 2 && m_beats == 3) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("reset_point_budget", 1'b0, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_awvalid", axi_awvalid, 1'b0);
    check("arst_wvalid", axi_wvalid, 1'b0);
    check("arst_wlast", axi_wlast, 1'b0);
    check("arst_data_req", wr_data_req, 4'b0000);
    check("arst_bready", axi_bready, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_wdata", axi_wdata, '0);
    check("arst_awaddr", axi_awaddr, '0);
    model_reset();
    wr_req = 4'b0000;
    @(posedge clk);
    #3;
    rstn = 1'b1;
    set_knobs(100, 100, 100, 100, 0, 1'b0);
    new_request(0);
    run_until_done(m_done_cnt + 1, 40);
    wr_req = 4'b0000;
    for (int i = 0; i < 5; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/video_wr_arbiter.md
Name: video_wr_arbiter

Overview:
Four-port write arbiter. It shares the single DDR3 controller AXI write channel between the frame writers: HDMI-in plus the two CMOS inputs, with one spare port.
- Each writer requests one fixed-length burst at a time.
- The arbiter grants the writers round-robin and drives AW, W and B for the granted burst.
- It forwards beat-accept strobes back to the writer and signals completion.
- It sits between the per-source frame-write FIFOs and the DDR IP AXI slave port, in the DDR controller clock domain.

Parameters:
CTRL_ADDR_WIDTH, 28, AXI byte address width.
AXI_DATA_WIDTH, 256, AXI data width (MEM_DQ_WIDTH*8).
M_AXI_BRUST_LEN, 8, beats per burst, range 1..16.

Ports:
clk  in  1  DDR controller AXI clock.
rstn  in  1  reset, asynchronous, active-low.
ddr_init_done  in  1  DDR calibration complete; no new burst is started while low.
wr_req  in  4  per-channel burst request; level signal.
wr_addr  in  4*CTRL_ADDR_WIDTH  burst start address; channel n at bits [n*W +: W].
wr_data  in  4*AXI_DATA_WIDTH  current beat data per channel; first-word-fall-through.
wr_grant  out  4  one-hot, one-cycle pulse when a channel's burst is accepted.
wr_data_req  out  4  one-hot beat-consumed strobe; the writer advances its FIFO on this strobe.
wr_done  out  4  one-hot, one-cycle pulse on write response.
axi_awaddr  out  CTRL_ADDR_WIDTH  latched burst address.
axi_awlen  out  4  constant M_AXI_BRUST_LEN-1.
axi_awvalid  out  1
axi_awready  in  1
axi_wdata  out  AXI_DATA_WIDTH  selected channel's wr_data.
axi_wstrb  out  AXI_DATA_WIDTH/8  all ones.
axi_wlast  out  1
axi_wvalid  out  1
axi_wready  in  1
axi_bvalid  in  1
axi_bready  out  1
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE, all outputs 0 (except axi_wstrb all ones, axi_awlen constant), sel=0, rr_last=3 so channel 0 wins first.
- FSM states: IDLE, AW, W, B.
- IDLE
  - Requires ddr_init_done=1 and wr_req!=0.
  - Picks the first set request scanning rr_last+1, rr_last+2, ... modulo 4.
  - Registers sel and wr_addr[sel] into axi_awaddr; moves to AW.
  - wr_grant[sel] pulses in the first AW cycle.
  - Request-to-awvalid latency is exactly 1 cycle.
- AW
  - axi_awvalid=1, with address held stable until axi_awready.
  - On handshake: awvalid drops next cycle, beat counter cleared, move to W.
- W
  - axi_wvalid=1; axi_wdata is combinationally muxed from wr_data[sel].
  - wr_data_req[sel] = axi_wvalid & axi_wready, same cycle.
  - Beat counter increments on each handshake.
  - axi_wlast=1 when count == M_AXI_BRUST_LEN-1 (so for length 1, wlast is set on the first beat).
  - Handshake with wlast moves to B.
  - Stalls on axi_wready=0 produce no strobe and hold data.
- B
  - axi_bready=1.
  - On axi_bvalid: wr_done[sel] pulses, rr_last<=sel, return to IDLE.
  - The response code is ignored.
- Back-to-back: a request still high in the IDLE cycle after wr_done is a new burst. Minimum 1 IDLE cycle between bursts.
- Requester contract: hold wr_req until wr_grant and keep wr_addr stable until then. Data must be valid whenever wr_data_req could fire.
- If ddr_init_done falls mid-burst, the burst completes normally; only new starts are blocked.
- Async reset mid-burst: immediate return to IDLE with all valids dropped. The partial burst is abandoned; the DDR IP is reset with it.
- Exactly one of wr_grant / wr_data_req / wr_done is ever non-zero per channel-select, and all are one-hot to sel.

Optional Feature:
Macro ARB_CH0_PRIORITY_EN.
- Defined: in IDLE, channel 0 (HDMI input) wins whenever wr_req[0]=1, regardless of rr_last. Channels 1-3 round-robin among themselves; rr_last is updated only when a channel 1-3 is served.
- Undefined: pure 4-way round-robin as above.

Test Plan:
1. ddr_init_done=0, wr_req=4'b0100 → no awvalid. Raise init_done → wr_grant=4'b0100 one cycle after, axi_awaddr=wr_addr[2].
2. wr_req=4'b1111 held, M_AXI_BRUST_LEN=8, awready/wready/bvalid always 1 → wr_done order ch0,1,2,3,0. Each burst has 8 W beats, wlast on the 8th, 8 wr_data_req pulses to the served channel.
3. axi_awready low 5 cycles, then axi_wready toggling 1010... → awaddr stable during stall, wr_data_req only on wready=1 cycles, wlast on the 8th accepted beat.
4. After ch1 served, wr_req=4'b0011 → ch0 is not skipped: next grant is ch0 (rr scan 2,3,0). With ARB_CH0_PRIORITY_EN and wr_req=4'b1110 held plus ch0 pulsed every burst → ch0 served between every other burst.
5. Assert rstn=0 during beat 4 of a burst → all outputs 0 asynchronously; after release, wr_req=4'b0001 → fresh burst with beat count from 0.
6. bvalid delayed 20 cycles → bready held, no new awvalid, busy=1, wr_done on the bvalid cycle.
